// File: rtl/comb_feedback_ctrl.sv
// comb_feedback_ctrl: control and arithmetic stage of a reverb comb filter.
// Computes y[n] = x[n] + g*y[n-D] over a four-state sequence and writes
// y[n] back into the external delay line with a single enable pulse.
// The delay-line tap is captured at accept time, so the shift caused by our
// own push never disturbs the sample currently being computed.
module comb_feedback_ctrl #(
  parameter int WIDTH  = 12,
  parameter int GAIN_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [WIDTH-1:0]  x_in,
  input  logic [GAIN_W-1:0] gain,
  input  logic [WIDTH-1:0]  delayed_in,
  output logic [WIDTH-1:0]  fifo_din,
  output logic              fifo_enable,
  output logic [WIDTH-1:0]  y_out,
  output logic              y_valid,
  output logic              busy,
  output logic              overrun
);

  // Product width: signed sample times a sign-padded unsigned gain.
  localparam int PW = WIDTH + GAIN_W + 1;

  // Saturation bounds expressed at product width so the whole sum is compared.
  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ADD  = 2'd2,
    S_PUSH = 2'd3
  } state_e;

  // Clamp a wide signed sum into the signed WIDTH-bit range.
  function automatic logic [WIDTH-1:0] saturate(input logic signed [PW-1:0] v);
    logic [WIDTH-1:0] r;
    if (v > SAT_MAX) begin
      r = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (v < SAT_MIN) begin
      r = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      r = v[WIDTH-1:0];
    end
    return r;
  endfunction

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       x_q, x_d;
  logic [GAIN_W-1:0]      gain_q, gain_d;
  logic [WIDTH-1:0]       delayed_q, delayed_d;
  logic signed [PW-1:0]   product_q, product_d;
  logic [WIDTH-1:0]       y_q, y_d;
  logic [WIDTH-1:0]       fifo_din_q, fifo_din_d;
  logic [WIDTH-1:0]       y_out_q, y_out_d;
  logic                   fifo_enable_q, fifo_enable_d;
  logic                   y_valid_q, y_valid_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;

  logic signed [PW-1:0]   delayed_ext_s;
  logic signed [PW-1:0]   gain_ext_s;
  logic signed [PW-1:0]   x_ext_s;
  logic signed [PW-1:0]   scaled_s;
  logic signed [PW-1:0]   sum_s;

  // Next-state, datapath and output decode for the IDLE/MUL/ADD/PUSH sequence.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    gain_d        = gain_q;
    delayed_d     = delayed_q;
    product_d     = product_q;
    y_d           = y_q;
    fifo_din_d    = fifo_din_q;
    y_out_d       = y_out_q;
    fifo_enable_d = 1'b0;
    y_valid_d     = 1'b0;

    delayed_ext_s = {{(PW-WIDTH){delayed_q[WIDTH-1]}}, delayed_q};
    gain_ext_s    = {{(PW-GAIN_W){1'b0}}, gain_q};
    x_ext_s       = {{(PW-WIDTH){x_q[WIDTH-1]}}, x_q};
    // Arithmetic shift floors toward minus infinity, as the filter expects.
    scaled_s      = product_q >>> GAIN_W;
    sum_s         = x_ext_s + scaled_s;

    case (state_q)
      S_IDLE: begin
        if (sample_valid) begin
          x_d       = x_in;
          gain_d    = gain;
          delayed_d = delayed_in;
          state_d   = S_MUL;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_MUL: begin
        product_d = delayed_ext_s * gain_ext_s;
        state_d   = S_ADD;
      end
      S_ADD: begin
        y_d     = saturate(sum_s);
        state_d = S_PUSH;
      end
      S_PUSH: begin
        fifo_din_d    = y_q;
        y_out_d       = y_q;
        fifo_enable_d = 1'b1;
        y_valid_d     = 1'b1;
        state_d       = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A strobe arriving mid-computation is dropped and flagged permanently.
    if (sample_valid && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any in-flight sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      x_q           <= {WIDTH{1'b0}};
      gain_q        <= {GAIN_W{1'b0}};
      delayed_q     <= {WIDTH{1'b0}};
      product_q     <= {PW{1'b0}};
      y_q           <= {WIDTH{1'b0}};
      fifo_din_q    <= {WIDTH{1'b0}};
      y_out_q       <= {WIDTH{1'b0}};
      fifo_enable_q <= 1'b0;
      y_valid_q     <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      gain_q        <= gain_d;
      delayed_q     <= delayed_d;
      product_q     <= product_d;
      y_q           <= y_d;
      fifo_din_q    <= fifo_din_d;
      y_out_q       <= y_out_d;
      fifo_enable_q <= fifo_enable_d;
      y_valid_q     <= y_valid_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
    end
  end

  assign fifo_din    = fifo_din_q;
  assign fifo_enable = fifo_enable_q;
  assign y_out       = y_out_q;
  assign y_valid     = y_valid_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

endmodule
